response_router_slave_pe: RTL and testbench



---
 rtl/response_router_slave_pe_if.sv | 31 +++
 rtl/response_router_slave_pe.sv | 97 +++++++++
 tb/tb_response_router_slave_pe.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/response_router_slave_pe_if.sv
// Request/response bundle between the arbitration tree, the slave-side router and one peripheral.
interface response_router_slave_pe_if #(
   parameter int N_MASTER   = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  data_req_i;
   logic [N_MASTER-1:0]   data_ID_i;
   logic                  data_gnt_o;
   logic                  data_req_o;
   logic                  data_gnt_i;
   logic                  data_r_valid_i;
   logic [DATA_WIDTH-1:0] data_r_rdata_i;
   logic                  data_r_opc_i;
   logic [N_MASTER-1:0]   data_r_valid_o;
   logic [DATA_WIDTH-1:0] data_r_rdata_o;
   logic                  data_r_opc_o;

   modport slave (
      input  data_req_i, data_ID_i, data_gnt_i,
      input  data_r_valid_i, data_r_rdata_i, data_r_opc_i,
      output data_gnt_o, data_req_o,
      output data_r_valid_o, data_r_rdata_o, data_r_opc_o
   );

   modport master (
      output data_req_i, data_ID_i, data_gnt_i,
      output data_r_valid_i, data_r_rdata_i, data_r_opc_i,
      input  data_gnt_o, data_req_o,
      input  data_r_valid_o, data_r_rdata_o, data_r_opc_o
   );
endinterface

// File: rtl/response_router_slave_pe.sv
// Slave-side response router: in-order FIFO of granted master IDs steers peripheral responses home.
// Define RESP_ROUTER_OUT_REG_EN to register the response outputs (1-cycle latency).
module response_router_slave_pe #(
   parameter int N_MASTER        = 8,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   response_router_slave_pe_if.slave              bus,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                                   resp_err_o
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   logic [N_MASTER-1:0] fifo_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                full, push, pop;
   logic [N_MASTER-1:0] head_id;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      full    = (cnt_q == MAX_CNT);
      push    = bus.data_req_i & bus.data_gnt_i & ~full;
      pop     = bus.data_r_valid_i & (cnt_q != '0);
      head_id = fifo_q[rptr_q];
      wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
      err_d   = err_q | (bus.data_r_valid_i & (cnt_q == '0));
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   // ID storage carries no reset; occupancy is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= bus.data_ID_i;
   end

   assign bus.data_req_o = bus.data_req_i & ~full;
   assign bus.data_gnt_o = bus.data_gnt_i & ~full;
   assign outstanding_o  = cnt_q;
   assign resp_err_o     = err_q;

`ifdef RESP_ROUTER_OUT_REG_EN
   logic [N_MASTER-1:0]   vld_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  opc_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q   <= '0;
         rdata_q <= '0;
         opc_q   <= 1'b0;
      end else begin
         vld_q <= head_id & {N_MASTER{pop}};
         if (pop) begin
            rdata_q <= bus.data_r_rdata_i;
            opc_q   <= bus.data_r_opc_i;
         end
      end
   end

   assign bus.data_r_valid_o = vld_q;
   assign bus.data_r_rdata_o = rdata_q;
   assign bus.data_r_opc_o   = opc_q;
`else
   assign bus.data_r_valid_o = head_id & {N_MASTER{pop}};
   assign bus.data_r_rdata_o = bus.data_r_rdata_i;
   assign bus.data_r_opc_o   = bus.data_r_opc_i;
`endif
endmodule

// File: tb/tb_response_router_slave_pe.sv
// Scoreboard bench for response_router_slave_pe: granted IDs are queued, responses checked in order.
module tb_response_router_slave_pe;
   localparam int NM = 8;
   localparam int DW = 32;
   localparam int MO = 4;
`ifdef RESP_ROUTER_OUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      logic [NM-1:0] id;
      logic [DW-1:0] d;
      logic          opc;
      int            due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    outstanding;
   logic          resp_err;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            m_cnt = 0;
   logic          m_err = 1'b0;
   logic [NM-1:0] id_q[$];
   exp_t          exp_q[$];

   response_router_slave_pe_if #(.N_MASTER(NM), .DATA_WIDTH(DW)) bus ();

   response_router_slave_pe #(.N_MASTER(NM), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .outstanding_o(outstanding),
      .resp_err_o   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic step(input logic req, input logic gnt, input logic [NM-1:0] id,
                       input logic rv, input logic [DW-1:0] d, input logic opc);
      exp_t e;
      bit   push, pop, full_pre;
      bus.data_req_i     = req;
      bus.data_gnt_i     = gnt;
      bus.data_ID_i      = id;
      bus.data_r_valid_i = rv;
      bus.data_r_rdata_i = d;
      bus.data_r_opc_i   = opc;
      full_pre = (m_cnt == MO);
      push = req && gnt && !full_pre;
      pop  = rv && (m_cnt != 0);
      if (rv && m_cnt == 0) m_err = 1'b1;
      if (pop) begin
         e.id = id_q.pop_front(); e.d = d; e.opc = opc; e.due = cyc + LAT;
         exp_q.push_back(e);
      end
      if (push) id_q.push_back(id);
      m_cnt = m_cnt + int'(push) - int'(pop);
      @(negedge clk);
      total++;
      if (bus.data_gnt_o !== (gnt & ~full_pre) || bus.data_req_o !== (req & ~full_pre)) begin
         bad++;
         $display("FAIL gating cyc=%0d got gnt=%b req=%b want gnt=%b req=%b", cyc,
                  bus.data_gnt_o, bus.data_req_o, gnt & ~full_pre, req & ~full_pre);
      end
      total++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         if (bus.data_r_valid_o !== e.id || bus.data_r_rdata_o !== e.d || bus.data_r_opc_o !== e.opc) begin
            bad++;
            $display("FAIL resp_route cyc=%0d got vld=%h d=%h opc=%b want vld=%h d=%h opc=%b", cyc,
                     bus.data_r_valid_o, bus.data_r_rdata_o, bus.data_r_opc_o, e.id, e.d, e.opc);
         end
      end else if (bus.data_r_valid_o !== '0) begin
         bad++;
         $display("FAIL spurious_valid cyc=%0d got vld=%h want 00", cyc, bus.data_r_valid_o);
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.data_req_i = 1'b0; bus.data_gnt_i = 1'b0; bus.data_ID_i = '0;
      bus.data_r_valid_i = 1'b0; bus.data_r_rdata_i = '0; bus.data_r_opc_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_cnt = 0; m_err = 1'b0; id_q.delete(); exp_q.delete();
      cyc++;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (bus.data_r_valid_o !== '0 || bus.data_r_rdata_o !== '0 || bus.data_r_opc_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_resp got vld=%h d=%h opc=%b want 0", bus.data_r_valid_o, bus.data_r_rdata_o, bus.data_r_opc_o);
      end
      total++;
      if (outstanding !== 3'd0 || resp_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got outstanding=%0d err=%b want 0 0", outstanding, resp_err);
      end
      total++;
      if (bus.data_gnt_o !== 1'b0 || bus.data_req_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_gate got gnt=%b req=%b want 0 0", bus.data_gnt_o, bus.data_req_o);
      end
      bus.data_req_i = 1'b1; bus.data_gnt_i = 1'b1;
      #1;
      total++;
      if (bus.data_gnt_o !== 1'b1 || bus.data_req_o !== 1'b1) begin
         bad++;
         $display("FAIL reset_pass_gate got gnt=%b req=%b want 1 1", bus.data_gnt_o, bus.data_req_o);
      end
      bus.data_req_i = 1'b0; bus.data_gnt_i = 1'b0;
      #1;
   endtask

   task automatic test_single();
      step(1'b1, 1'b1, 8'h04, 1'b0, '0, 1'b0);
      total++;
      if (outstanding !== 3'd1) begin
         bad++; $display("FAIL single_count1 got %0d want 1", outstanding);
      end
      idle(1);
      step(1'b0, 1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      total++;
      if (outstanding !== 3'd0) begin
         bad++; $display("FAIL single_count0 got %0d want 0", outstanding);
      end
      idle(2);
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL single_missing got pending=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [NM-1:0] ids [4] = '{8'h01, 8'h80, 8'h10, 8'h02};
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, ids[i], 1'b0, '0, 1'b0);
      total++;
      if (outstanding !== 3'd4) begin
         bad++; $display("FAIL b2b_full_count got %0d want 4", outstanding);
      end
      bus.data_req_i = 1'b1; bus.data_gnt_i = 1'b1; bus.data_ID_i = 8'h40;
      #1;
      total++;
      if (bus.data_gnt_o !== 1'b0 || bus.data_req_o !== 1'b0) begin
         bad++; $display("FAIL b2b_full_gate got gnt=%b req=%b want 0 0", bus.data_gnt_o, bus.data_req_o);
      end
      step(1'b1, 1'b1, 8'h40, 1'b1, 32'h1111_0001, 1'b1);
      total++;
      if (outstanding !== 3'd3) begin
         bad++; $display("FAIL b2b_pop_while_full got %0d want 3", outstanding);
      end
      total++;
      if (bus.data_gnt_o !== 1'b1) begin
         bad++; $display("FAIL b2b_regrant got gnt=%b want 1", bus.data_gnt_o);
      end
      step(1'b0, 1'b0, '0, 1'b1, 32'h2222_0002, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 32'h3333_0003, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 32'h4444_0004, 1'b0);
      idle(2);
      total++;
      if (outstanding !== 3'd0 || exp_q.size() != 0) begin
         bad++; $display("FAIL b2b_drain got count=%0d pending=%0d want 0 0", outstanding, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      logic [NM-1:0] id;
      for (int i = 0; i < 10; i++) begin
         id = NM'(1) << ((i * 3) % NM);
         step(1'b1, 1'b1, id, 1'b0, '0, 1'b0);
         step(1'b0, 1'b0, '0, 1'b1, 32'hA000_0000 + DW'(i), i[0]);
      end
      idle(2);
      total++;
      if (outstanding !== 3'd0 || exp_q.size() != 0) begin
         bad++; $display("FAIL wrap_drain got count=%0d pending=%0d want 0 0", outstanding, exp_q.size());
      end
   endtask

   task automatic test_same_cycle();
      step(1'b1, 1'b1, 8'h08, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 8'h04, 1'b0, '0, 1'b0);
      total++;
      if (outstanding !== 3'd2) begin
         bad++; $display("FAIL same_pre got %0d want 2", outstanding);
      end
      step(1'b1, 1'b1, 8'h20, 1'b1, 32'h5555_AAAA, 1'b1);
      total++;
      if (outstanding !== 3'd2) begin
         bad++; $display("FAIL same_hold got %0d want 2", outstanding);
      end
      step(1'b0, 1'b0, '0, 1'b1, 32'h6666_0001, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 32'h7777_0002, 1'b1);
      idle(2);
      total++;
      if (outstanding !== 3'd0 || exp_q.size() != 0) begin
         bad++; $display("FAIL same_drain got count=%0d pending=%0d want 0 0", outstanding, exp_q.size());
      end
   endtask

   task automatic test_orphan_reset();
      step(1'b0, 1'b0, '0, 1'b1, 32'hBAD0_0001, 1'b1);
      total++;
      if (resp_err !== m_err) begin
         bad++; $display("FAIL orphan_err got %b want %b", resp_err, m_err);
      end
      idle(2);
      total++;
      if (resp_err !== 1'b1 || outstanding !== 3'd0) begin
         bad++; $display("FAIL orphan_sticky got err=%b count=%0d want 1 0", resp_err, outstanding);
      end
      step(1'b1, 1'b1, 8'h01, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 8'h02, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 8'h04, 1'b0, '0, 1'b0);
      total++;
      if (outstanding !== 3'd3) begin
         bad++; $display("FAIL midreset_pre got %0d want 3", outstanding);
      end
      do_reset();
      total++;
      if (outstanding !== 3'd0 || resp_err !== 1'b0 || bus.data_r_valid_o !== '0) begin
         bad++;
         $display("FAIL midreset_clear got count=%0d err=%b vld=%h want 0 0 00", outstanding, resp_err, bus.data_r_valid_o);
      end
      step(1'b0, 1'b0, '0, 1'b1, 32'hBAD0_0002, 1'b0);
      idle(1);
      total++;
      if (resp_err !== 1'b1) begin
         bad++; $display("FAIL midreset_orphan got err=%b want 1", resp_err);
      end
   endtask

   initial begin
      bus.data_req_i = 1'b0; bus.data_gnt_i = 1'b0; bus.data_ID_i = '0;
      bus.data_r_valid_i = 1'b0; bus.data_r_rdata_i = '0; bus.data_r_opc_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_same_cycle();
      test_orphan_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
